// File: rtl/signal_meter_pkg.sv
// signal_meter_pkg: shared types and constants for the signal_meter block.
// Holds the FSM state encoding, default counter width, the saturation
// constant helper and the reset values of the optional peak trackers.
package signal_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_DONE
    } state_e;

    localparam int CNT_W_DEFAULT = 16;

    localparam logic signed [7:0] PEAK_MAX_INIT = 8'sh80;
    localparam logic signed [7:0] PEAK_MIN_INIT = 8'sh7F;

    // All-ones value of a w-bit unsigned counter.
    function automatic logic [63:0] cnt_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous 1-bit input into the clk domain
// through a SYNC_STAGES-deep flop chain, then compares the synchronised level
// against a one-cycle history flop to produce single-cycle rise/fall pulses.
module sync_edge_detect
    import signal_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    // Shift the raw input into the chain and remember the previous level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Register the synchroniser chain and the history bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/signal_meter.sv
// signal_meter: measures period and high time (in clk cycles) of a periodic
// asynchronous 1-bit signal and presents each result on a valid/ready port.
// Optional feature macro SIGNAL_METER_PEAK_EN adds signed max/min tracking
// of the 'sample' stream over the measured period.
module signal_meter
    import signal_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    start,
    input  logic                    sig_in,
    input  logic signed [7:0]       sample,
    output logic                    busy,
    output logic                    valid,
    input  logic                    ready,
    output logic [CNT_W-1:0]        period,
    output logic [CNT_W-1:0]        high_time,
    output logic                    timeout
`ifdef SIGNAL_METER_PEAK_EN
    ,
    output logic signed [7:0]       peak_max,
    output logic signed [7:0]       peak_min
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic sig_level_unused;
    logic rise;
    logic fall;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .level  (sig_level_unused),
        .rise   (rise),
        .fall   (fall)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             high_seen_q, high_seen_d;
    logic [CNT_W-1:0] high_lat_q, high_lat_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             timeout_q, timeout_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

`ifdef SIGNAL_METER_PEAK_EN
    logic signed [7:0] run_max_q, run_max_d;
    logic signed [7:0] run_min_q, run_min_d;
    logic signed [7:0] peak_max_q, peak_max_d;
    logic signed [7:0] peak_min_q, peak_min_d;
`else
    logic unused_sample;
    assign unused_sample = ^sample;
`endif

    // Next-state logic: counting, edge-driven latching and saturation handling.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        high_seen_d = high_seen_q;
        high_lat_d  = high_lat_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        timeout_d   = timeout_q;
`ifdef SIGNAL_METER_PEAK_EN
        run_max_d   = run_max_q;
        run_min_d   = run_min_q;
        peak_max_d  = peak_max_q;
        peak_min_d  = peak_min_q;
`endif
        cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start && enable) begin
                    state_d     = ST_ARM;
                    cnt_d       = '0;
                    timeout_d   = 1'b0;
                    high_seen_d = 1'b0;
                end
            end
            ST_ARM: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
`ifdef SIGNAL_METER_PEAK_EN
                    run_max_d = sample;
                    run_min_d = sample;
`endif
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d     = ST_DONE;
                        timeout_d   = 1'b1;
                        period_d    = CNT_MAX;
                        high_time_d = CNT_MAX;
`ifdef SIGNAL_METER_PEAK_EN
                        peak_max_d  = PEAK_MAX_INIT;
                        peak_min_d  = PEAK_MIN_INIT;
`endif
                    end
                end
            end
            ST_MEASURE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (rise) begin
                    state_d     = ST_DONE;
                    period_d    = cnt_q;
                    high_time_d = high_lat_q;
`ifdef SIGNAL_METER_PEAK_EN
                    peak_max_d  = run_max_q;
                    peak_min_d  = run_min_q;
`endif
                end else begin
`ifdef SIGNAL_METER_PEAK_EN
                    run_max_d = (sample > run_max_q) ? sample : run_max_q;
                    run_min_d = (sample < run_min_q) ? sample : run_min_q;
`endif
                    if (fall && !high_seen_q) begin
                        high_seen_d = 1'b1;
                        high_lat_d  = cnt_q;
                    end
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d     = ST_DONE;
                        timeout_d   = 1'b1;
                        period_d    = CNT_MAX;
                        high_time_d = high_seen_d ? high_lat_d : CNT_MAX;
`ifdef SIGNAL_METER_PEAK_EN
                        peak_max_d  = run_max_d;
                        peak_min_d  = run_min_d;
`endif
                    end
                end
            end
            ST_DONE: begin
                if (valid_q && ready) begin
                    if (start && enable) begin
                        state_d     = ST_ARM;
                        cnt_d       = '0;
                        timeout_d   = 1'b0;
                        high_seen_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Register FSM state, counters and all outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            high_seen_q <= 1'b0;
            high_lat_q  <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            timeout_q   <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SIGNAL_METER_PEAK_EN
            run_max_q   <= PEAK_MAX_INIT;
            run_min_q   <= PEAK_MIN_INIT;
            peak_max_q  <= PEAK_MAX_INIT;
            peak_min_q  <= PEAK_MIN_INIT;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_seen_q <= high_seen_d;
            high_lat_q  <= high_lat_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            timeout_q   <= timeout_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
`ifdef SIGNAL_METER_PEAK_EN
            run_max_q   <= run_max_d;
            run_min_q   <= run_min_d;
            peak_max_q  <= peak_max_d;
            peak_min_q  <= peak_min_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign period    = period_q;
    assign high_time = high_time_q;
    assign timeout   = timeout_q;
`ifdef SIGNAL_METER_PEAK_EN
    assign peak_max  = peak_max_q;
    assign peak_min  = peak_min_q;
`endif

endmodule

// File: tb/tb_signal_meter.sv
// tb_signal_meter: randomized self-checking bench for signal_meter.
// The waveform generator drives sig_in from (mode, period, high) settings and
// the reference model predicts results directly from those settings.
module tb_signal_meter;

    localparam int CNT_W   = 8;
    localparam int SAT     = 255;
    localparam int LEAD    = 8;
    localparam int WAIT_MAX = 700;

    logic                    clk;
    logic                    reset;
    logic                    enable;
    logic                    start;
    logic                    sig_in;
    logic signed [7:0]       sample;
    logic                    busy;
    logic                    valid;
    logic                    ready;
    logic [CNT_W-1:0]        period;
    logic [CNT_W-1:0]        high_time;
    logic                    timeout;
`ifdef SIGNAL_METER_PEAK_EN
    logic signed [7:0]       peak_max;
    logic signed [7:0]       peak_min;
`endif

    int checks = 0;
    int errors = 0;

    int wave_mode = 0;
    int wave_per  = 2;
    int wave_high = 1;
    int wave_gen  = 0;
    logic signed [7:0] sample_tab [0:255];

    int last_period = 0;
    int last_high   = 0;

    signal_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .start     (start),
        .sig_in    (sig_in),
        .sample    (sample),
        .busy      (busy),
        .valid     (valid),
        .ready     (ready),
        .period    (period),
        .high_time (high_time),
        .timeout   (timeout)
`ifdef SIGNAL_METER_PEAK_EN
        ,
        .peak_max  (peak_max),
        .peak_min  (peak_min)
`endif
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waveform generator: restarts its phase whenever the settings change.
    initial begin
        int seen_gen = 0;
        int phase = 0;
        sig_in = 1'b0;
        sample = '0;
        forever begin
            @(negedge clk);
            #1;
            if (seen_gen != wave_gen) begin
                seen_gen = wave_gen;
                phase = 0;
            end
            case (wave_mode)
                1: begin
                    sig_in = ((phase % wave_per) < wave_high);
                    sample = sample_tab[phase % wave_per];
                end
                2: sig_in = (phase >= LEAD);
                3: sig_in = (phase >= LEAD) && (phase < LEAD + wave_high);
                default: sig_in = 1'b0;
            endcase
            if (phase < 100000) phase++;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic setWave(input int mode, input int per, input int high);
        wave_mode = mode;
        wave_per  = per;
        wave_high = high;
        wave_gen++;
    endtask

    task automatic fillRandomTable(input int per);
        for (int i = 0; i < per; i++) sample_tab[i] = 8'($urandom_range(0, 255));
    endtask

    // Reference model: expected result from the waveform description alone.
    task automatic modelResult(input int mode, input int per, input int high,
                               output int ep, output int eh, output int et);
        case (mode)
            1: begin ep = per; eh = high; et = 0; end
            3: begin ep = SAT; eh = high; et = 1; end
            default: begin ep = SAT; eh = SAT; et = 1; end
        endcase
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for valid; cycles counts rising edges after the start-accept edge.
    task automatic waitValid(output int cycles, output bit ok);
        cycles = 0;
        while (!valid && cycles < WAIT_MAX) begin
            @(negedge clk);
            cycles++;
        end
        ok = valid;
        if (!ok) checkOutput("valid_wait_expired", 0, 1);
    endtask

    task automatic checkResult(input int mode, input int per, input int high);
        int ep, eh, et;
        modelResult(mode, per, high, ep, eh, et);
        checkOutput("period", int'(period), ep);
        checkOutput("high_time", int'(high_time), eh);
        checkOutput("timeout", int'(timeout), et);
`ifdef SIGNAL_METER_PEAK_EN
        if (mode == 1) begin
            int mx = -128;
            int mn = 127;
            for (int i = 0; i < per; i++) begin
                if (int'(sample_tab[i]) > mx) mx = int'(sample_tab[i]);
                if (int'(sample_tab[i]) < mn) mn = int'(sample_tab[i]);
            end
            checkOutput("peak_max", int'(peak_max), mx);
            checkOutput("peak_min", int'(peak_min), mn);
        end
`endif
        last_period = ep;
        last_high   = eh;
    endtask

    // Hold off the consumer, confirm results stay put, then complete the handshake.
    task automatic drainResult(input int ready_delay);
        int p0 = int'(period);
        int h0 = int'(high_time);
        int stable = 1;
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            if (!valid || int'(period) != p0 || int'(high_time) != h0) stable = 0;
        end
        if (ready_delay > 0) checkOutput("hold_stable", stable, 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        checkOutput("valid_drop", int'(valid), 0);
        checkOutput("busy_drop", int'(busy), 0);
    endtask

    task automatic applyStimulus(input int mode, input int per, input int high, input int ready_delay);
        int cycles;
        bit ok;
        setWave(mode, per, high);
        repeat (4) @(negedge clk);
        pulseStart();
        checkOutput("busy_rise", int'(busy), 1);
        waitValid(cycles, ok);
        if (!ok) return;
        checkResult(mode, per, high);
        if (mode == 0) checkOutput("arm_latency", cycles, SAT);
        drainResult(ready_delay);
    endtask

    // Start a period-60 measurement and return a few cycles into MEASURE.
    task automatic startIntoMeasure();
        int n = 0;
        logic prev;
        setWave(1, 60, 20);
        repeat (4) @(negedge clk);
        pulseStart();
        prev = sig_in;
        while (!(sig_in && !prev) && n < 200) begin
            prev = sig_in;
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("rise_wait_expired", 0, 1);
        repeat (15) @(negedge clk);
    endtask

    task automatic watchNoValid(input string tag, input int span);
        int seen = 0;
        for (int i = 0; i < span; i++) begin
            @(negedge clk);
            if (valid) seen = 1;
        end
        checkOutput(tag, seen, 0);
    endtask

    initial begin
        int per, high, cycles;
        bit ok;
        reset  = 1'b1;
        enable = 1'b1;
        start  = 1'b0;
        ready  = 1'b0;
        for (int i = 0; i < 256; i++) sample_tab[i] = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_valid", int'(valid), 0);
        checkOutput("rst_timeout", int'(timeout), 0);
        checkOutput("rst_period", int'(period), 0);
        checkOutput("rst_high", int'(high_time), 0);
`ifdef SIGNAL_METER_PEAK_EN
        checkOutput("rst_peak_max", int'(peak_max), -128);
        checkOutput("rst_peak_min", int'(peak_min), 127);
`endif
        reset = 1'b0;

        $display("[TB] period 5 high 1");
        fillRandomTable(5);
        applyStimulus(1, 5, 1, 0);

        $display("[TB] period 16 high 8, ramp samples, ready held 20 cycles");
        for (int i = 0; i < 16; i++) sample_tab[i] = 8'(-40 + (i * 140) / 15);
        applyStimulus(1, 16, 8, 20);

        $display("[TB] constant low input, ARM saturation");
        applyStimulus(0, 2, 1, 2);

        $display("[TB] step input, MEASURE saturation without fall");
        applyStimulus(2, 2, 1, 1);

        $display("[TB] single pulse, MEASURE saturation after fall");
        applyStimulus(3, 2, 30, 1);

        $display("[TB] randomized periodic inputs");
        for (int t = 0; t < 8; t++) begin
            per  = $urandom_range(2, 120);
            high = $urandom_range(1, per - 1);
            fillRandomTable(per);
            applyStimulus(1, per, high, $urandom_range(0, 5));
        end

        $display("[TB] enable dropped mid-measurement");
        startIntoMeasure();
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_valid", int'(valid), 0);
        checkOutput("abort_period", int'(period), last_period);
        checkOutput("abort_high", int'(high_time), last_high);
        watchNoValid("abort_no_valid", 80);

        $display("[TB] start coincident with handshake");
        setWave(1, 16, 8);
        fillRandomTable(16);
        repeat (4) @(negedge clk);
        pulseStart();
        waitValid(cycles, ok);
        if (ok) begin
            checkResult(1, 16, 8);
            ready = 1'b1;
            start = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            start = 1'b0;
            checkOutput("b2b_valid_drop", int'(valid), 0);
            checkOutput("b2b_busy", int'(busy), 1);
            waitValid(cycles, ok);
            if (ok) begin
                checkResult(1, 16, 8);
                drainResult(0);
            end
        end

        $display("[TB] reset mid-measurement");
        startIntoMeasure();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mrst_busy", int'(busy), 0);
        checkOutput("mrst_valid", int'(valid), 0);
        checkOutput("mrst_period", int'(period), 0);
        checkOutput("mrst_high", int'(high_time), 0);
        checkOutput("mrst_timeout", int'(timeout), 0);
        reset = 1'b0;
        watchNoValid("mrst_no_valid", 80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
